// File: rtl/hub75_scan_scheduler.sv
// rtl/hub75_scan_scheduler.sv - HUB75 row/bit-plane scan scheduler with binary-coded modulation
//
// Purpose: walks every row and every bit plane of a frame slice. For each
// row/plane it asks the shifter to load the data. It then blanks the panel,
// latches the row and lights the row for BASE_TICKS << plane cycles.
//
// Ports:
//   clk_in       in   single clock, rising edge
//   rst_in       in   asynchronous active-low reset
//   frame_valid  in   a frame slice is available
//   frame_ready  out  scheduler is idle and will accept a slice
//   shift_start  out  one-cycle pulse: shifter loads shift_row/shift_plane
//   shift_row    out  row being shifted
//   shift_plane  out  plane being shifted
//   shift_done   in   shifter finished (single-cycle pulse)
//   hub75_addr   out  panel row address
//   hub75_latch  out  panel latch strobe
//   hub75_OE     out  panel output enable, active-low (1 = blanked)
//   frame_done   out  one-cycle pulse after the last row/plane
//   shift_err    out  sticky shift-watchdog error
//
// Optional feature: define SCAN_WATCHDOG_EN to abort the frame when
// shift_done does not arrive within WATCHDOG_CYCLES cycles.

module hub75_scan_scheduler #(
  parameter int SCAN_RATE       = 32,
  parameter int BIT_PLANES      = 3,
  parameter int BASE_TICKS      = 8,
  parameter int DEADTIME        = 2,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          frame_valid,
  output logic                          frame_ready,
  output logic                          shift_start,
  output logic [$clog2(SCAN_RATE)-1:0]  shift_row,
  output logic [$clog2(BIT_PLANES)-1:0] shift_plane,
  input  logic                          shift_done,
  output logic [$clog2(SCAN_RATE)-1:0]  hub75_addr,
  output logic                          hub75_latch,
  output logic                          hub75_OE,
  output logic                          frame_done,
  output logic                          shift_err
);

  localparam int ROW_W    = $clog2(SCAN_RATE);
  localparam int PL_W     = $clog2(BIT_PLANES);
  localparam int DISP_MAX = BASE_TICKS << (BIT_PLANES - 1);
  localparam int MAX_A    = (DISP_MAX > DEADTIME) ? DISP_MAX : DEADTIME;
  // One shared counter times BLANK, DISPLAY and the watchdog window.
  localparam int CNT_MAX  = (MAX_A > WATCHDOG_CYCLES) ? MAX_A : WATCHDOG_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT      = 3'd1,
    WAIT_SHIFT = 3'd2,
    BLANK      = 3'd3,
    LATCH      = 3'd4,
    DISPLAY    = 3'd5,
    NEXT       = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PL_W-1:0]    plane_q, plane_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   addr_q, addr_d;
  logic               latch_q, latch_d;
  logic               oe_q, oe_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic               last_row;
  logic               last_plane;
  logic [CNT_W-1:0]   disp_len;

  assign last_row   = (row_q == ROW_W'(SCAN_RATE - 1));
  assign last_plane = (plane_q == PL_W'(BIT_PLANES - 1));
  assign disp_len   = CNT_W'(BASE_TICKS) << plane_q;

`ifdef SCAN_WATCHDOG_EN
  logic err_q, err_d;
`endif

  // State register: every flop, including the registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      latch_q <= 1'b0;
      oe_q    <= 1'b1;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef SCAN_WATCHDOG_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      latch_q <= latch_d;
      oe_q    <= oe_d;
      start_q <= start_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef SCAN_WATCHDOG_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
`ifdef SCAN_WATCHDOG_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_valid && ready_q) begin
          row_d   = '0;
          plane_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: state_d = WAIT_SHIFT;
      WAIT_SHIFT: begin
        if (shift_done) begin
          state_d = BLANK;
`ifdef SCAN_WATCHDOG_EN
        end else if (cnt_q == CNT_W'(WATCHDOG_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
`endif
        end
      end
      BLANK: begin
        if (cnt_q == CNT_W'(DEADTIME - 1)) state_d = LATCH;
      end
      LATCH: state_d = DISPLAY;
      DISPLAY: begin
        if (cnt_q == disp_len - CNT_W'(1)) state_d = NEXT;
      end
      NEXT: begin
        if (last_plane) begin
          plane_d = '0;
          row_d   = last_row ? '0 : row_q + ROW_W'(1);
        end else begin
          plane_d = plane_q + PL_W'(1);
        end
        state_d = (last_plane && last_row) ? IDLE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
    // The counter restarts on every state entry, so it always holds the cycles already spent in the current state.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output logic: decoded from the next state so the flops line up with the state they describe.
  always_comb begin
    start_d = (state_d == SHIFT);
    latch_d = (state_d == LATCH);
    oe_d    = (state_d != DISPLAY);
    ready_d = (state_d == IDLE);
    // row_q/plane_q only move on leaving NEXT, so they still name the final slot here.
    done_d  = (state_d == NEXT) && last_plane && last_row;
    // Address moves on the first blanked cycle only, never while the row is lit.
    addr_d  = (state_d == BLANK && state_q != BLANK) ? row_q : addr_q;
  end

  assign frame_ready = ready_q;
  assign shift_start = start_q;
  assign shift_row   = row_q;
  assign shift_plane = plane_q;
  assign hub75_addr  = addr_q;
  assign hub75_latch = latch_q;
  assign hub75_OE    = oe_q;
  assign frame_done  = done_q;
`ifdef SCAN_WATCHDOG_EN
  assign shift_err   = err_q;
`else
  assign shift_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// tb/tb_hub75_scan_scheduler.sv - self-checking bench for hub75_scan_scheduler

module tb_hub75_scan_scheduler;

  localparam int SCAN_RATE       = 32;
  localparam int BIT_PLANES      = 3;
  localparam int BASE_TICKS      = 8;
  localparam int DEADTIME        = 2;
  localparam int WATCHDOG_CYCLES = 4096;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       frame_valid = 1'b0;
  logic       shift_done = 1'b0;
  logic       frame_ready, shift_start, hub75_latch, hub75_OE, frame_done, shift_err;
  logic [4:0] shift_row, hub75_addr;
  logic [1:0] shift_plane;

  hub75_scan_scheduler #(
    .SCAN_RATE(SCAN_RATE), .BIT_PLANES(BIT_PLANES), .BASE_TICKS(BASE_TICKS),
    .DEADTIME(DEADTIME), .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .shift_start(shift_start), .shift_row(shift_row), .shift_plane(shift_plane),
    .shift_done(shift_done), .hub75_addr(hub75_addr), .hub75_latch(hub75_latch),
    .hub75_OE(hub75_OE), .frame_done(frame_done), .shift_err(shift_err)
  );

  always #5 clk_in = ~clk_in;

  int cycle = 0;
  always @(posedge clk_in) cycle <= cycle + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Shifter responder: shift_done done_delay cycles after shift_start; with spur set,
  // extra pulses land in the SHIFT cycle and in the second BLANK cycle.
  bit resp_en = 1'b1;
  bit spur = 1'b0;
  int done_delay = 1;

  initial forever begin
    @(posedge clk_in); #1;
    if (resp_en) begin
      shift_done = 1'b0;
      if (shift_start) begin
        if (spur) shift_done = 1'b1;
        for (int i = 1; i < done_delay; i++) begin
          @(posedge clk_in); #1; shift_done = 1'b0;
        end
        @(posedge clk_in); #1; shift_done = 1'b1;
        if (spur) begin
          @(posedge clk_in); #1; shift_done = 1'b0;
          @(posedge clk_in); #1; shift_done = 1'b1;
        end
      end
    end
  end

  // Model: the expected sequence of (row, plane) slots, the lit-run length of each,
  // and whether a frame is in progress.
  int exp_row = 0, exp_plane = 0, run = 0, ts = 0;
  int prev_addr = 0;
  bit busy = 0, first_after = 1, wrap = 0, prev_oe = 1, prev_latch = 0, err_seen = 0;
  int n_start = 0, n_latch = 0, n_oe = 0, n_done = 0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      check("rst_oe", hub75_OE, 1);
      check("rst_latch", hub75_latch, 0);
      check("rst_addr", hub75_addr, 0);
      check("rst_shift_start", shift_start, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_shift_err", shift_err, 0);
      exp_row = 0; exp_plane = 0; run = 0; busy = 0; first_after = 1;
      prev_oe = 1; prev_latch = 0; prev_addr = 0; err_seen = 0;
    end else begin
      wrap = 0;
      if (shift_err && !err_seen) begin
        err_seen = 1;
        busy = 0;
      end
      check("frame_ready", frame_ready, first_after ? 0 : int'(!busy));
      first_after = 0;
      check("latch_while_lit", int'(hub75_latch && !hub75_OE), 0);
      check("addr_change_while_lit", int'(!hub75_OE && hub75_addr != prev_addr), 0);
      check("lit_outside_frame", int'(!hub75_OE && !busy), 0);
      if (shift_start) begin
        n_start++;
        ts = cycle;
        check("shift_row", shift_row, exp_row);
        check("shift_plane", shift_plane, exp_plane);
      end
      if (hub75_latch) begin
        n_latch++;
        check("latch_addr", hub75_addr, exp_row);
        check("latch_width", prev_latch, 0);
        if (resp_en) check("latch_delay", cycle - ts, done_delay + DEADTIME + 1);
      end
      if (!hub75_OE) begin
        run++;
        n_oe++;
      end else if (!prev_oe) begin
        check("oe_low_run", run, BASE_TICKS << exp_plane);
        run = 0;
        exp_plane++;
        if (exp_plane == BIT_PLANES) begin
          exp_plane = 0;
          exp_row++;
          if (exp_row == SCAN_RATE) begin
            exp_row = 0;
            wrap = 1;
          end
        end
      end
      check("frame_done", frame_done, wrap);
      if (frame_done) n_done++;
      if (frame_valid && frame_ready) busy = 1;
      if (frame_done) busy = 0;
      prev_oe = hub75_OE;
      prev_latch = hub75_latch;
      prev_addr = hub75_addr;
    end
  end

  task automatic zero_counts();
    n_start = 0; n_latch = 0; n_oe = 0; n_done = 0;
  endtask

  // Bounded wait; returns at posedge+1 of the cycle where the event is visible.
  task automatic wait_for(input int which, input int limit, input string name);
    bit hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(posedge clk_in); #1;
      case (which)
        0: hit = frame_done;
        1: hit = shift_start;
        2: hit = !hub75_OE;
        3: hit = shift_err;
        4: hit = hub75_latch;
        default: hit = shift_start && shift_row == 5'd17 && shift_plane == 2'd2;
      endcase
    end
    check(name, hit, 1);
  endtask

  int fd_cycle, ts4;

  initial begin
    #1 rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2 rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("idle_frame_ready", frame_ready, 1);
    check("idle_oe", hub75_OE, 1);
    check("idle_shift_err", shift_err, 0);

    // Frame 1: shift_done one cycle after each shift_start; frame_valid stays high.
    zero_counts();
    frame_valid = 1'b1;
    wait_for(0, 3000, "frame1_done_seen");
    fd_cycle = cycle;
    @(negedge clk_in); #1;
    check("frame1_shift_starts", n_start, 96);
    check("frame1_latches", n_latch, 96);
    check("frame1_oe_low_cycles", n_oe, 1792);
    check("frame1_frame_done", n_done, 1);
    zero_counts();
    done_delay = 3;
    spur = 1'b1;

    // Frame 2 is accepted back-to-back, with spurious shift_done pulses.
    wait_for(1, 10, "frame2_start_seen");
    check("restart_latency", cycle - fd_cycle, 2);
    check("restart_row", shift_row, 0);
    check("restart_plane", shift_plane, 0);
    frame_valid = 1'b0;
    repeat (500) @(posedge clk_in);
    #1 frame_valid = 1'b1;
    repeat (100) @(posedge clk_in);
    #1 frame_valid = 1'b0;
    wait_for(0, 4000, "frame2_done_seen");
    @(negedge clk_in); #1;
    check("frame2_shift_starts", n_start, 96);
    check("frame2_latches", n_latch, 96);
    check("frame2_oe_low_cycles", n_oe, 1792);
    check("frame2_frame_done", n_done, 1);
    zero_counts();
    repeat (20) @(posedge clk_in);
    #1;
    check("no_queued_frame", n_start, 0);
    check("post_frame2_ready", frame_ready, 1);

    // Frame 3: reset while row 17, plane 2 is lit.
    done_delay = 1;
    spur = 1'b0;
    frame_valid = 1'b1;
    wait_for(5, 3000, "row17_plane2_shift_seen");
    frame_valid = 1'b0;
    wait_for(2, 20, "row17_plane2_lit_seen");
    repeat (5) @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    check("async_rst_oe", hub75_OE, 1);
    check("async_rst_addr", hub75_addr, 0);
    check("async_rst_latch", hub75_latch, 0);
    check("async_rst_shift_start", shift_start, 0);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;
    zero_counts();
    repeat (40) @(posedge clk_in);
    #1;
    check("post_rst_shift_starts", n_start, 0);
    check("post_rst_latches", n_latch, 0);
    check("post_rst_oe_low", n_oe, 0);
    check("post_rst_ready", frame_ready, 1);

    // Frame 4: shift_done withheld.
    resp_en = 1'b0;
    shift_done = 1'b0;
    frame_valid = 1'b1;
    wait_for(1, 10, "wd_frame_start_seen");
    ts4 = cycle;
    frame_valid = 1'b0;
`ifdef SCAN_WATCHDOG_EN
    wait_for(3, WATCHDOG_CYCLES + 100, "wd_err_seen");
    check("wd_latency", cycle - ts4, 4097);
    check("wd_ready", frame_ready, 1);
    check("wd_latches", n_latch, 0);
    repeat (10) @(posedge clk_in);
    #1;
    check("wd_err_sticky", shift_err, 1);
    check("wd_no_frame_done", n_done, 0);
`else
    repeat (4200) @(posedge clk_in);
    #1;
    check("stall_shift_err", shift_err, 0);
    check("stall_oe", hub75_OE, 1);
    check("stall_latches", n_latch, 0);
    check("stall_ready", frame_ready, 0);
    shift_done = 1'b1;
    @(posedge clk_in);
    #1 shift_done = 1'b0;
    wait_for(4, 10, "late_done_latch_seen");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hub75_scan_scheduler.md
HUB75_SCAN_SCHEDULER -- requirements
Module: hub75_scan_scheduler

Interface
REQ-001 Parameter SCAN_RATE, default 32: number of row addresses scanned per frame slice.
REQ-002 Parameter BIT_PLANES, default 3: binary-coded-modulation planes per colour channel.
REQ-003 Parameter BASE_TICKS, default 8: OE-low cycles for plane 0.
REQ-004 Parameter DEADTIME, default 2: blanked cycles before each latch.
REQ-005 Parameter WATCHDOG_CYCLES, default 4096: shift timeout, used only under SCAN_WATCHDOG_EN.
REQ-006 Port clk_in  in  1: single clock; all logic on its rising edge.
REQ-007 Port rst_in  in  1: asynchronous, active-low reset.
REQ-008 Port frame_valid  in  1: frame slice data available.
REQ-009 Port frame_ready  out  1: scheduler accepts a new slice.
REQ-010 Port shift_start  out  1: one-cycle pulse commanding the shifter to load one row/plane.
REQ-011 Port shift_row  out  $clog2(SCAN_RATE): row being shifted.
REQ-012 Port shift_plane  out  $clog2(BIT_PLANES): plane being shifted.
REQ-013 Port shift_done  in  1: shifter finished; single-cycle pulse.
REQ-014 Port hub75_addr  out  $clog2(SCAN_RATE): panel row address.
REQ-015 Port hub75_latch  out  1: panel latch strobe.
REQ-016 Port hub75_OE  out  1: panel output enable, active-low (1 = blanked).
REQ-017 Port frame_done  out  1: one-cycle pulse after the last row/plane.
REQ-018 Port shift_err  out  1: sticky watchdog error flag.

Function
REQ-019 The FSM SHALL use states IDLE, SHIFT, WAIT_SHIFT, BLANK, LATCH, DISPLAY, NEXT.
REQ-020 IDLE: frame_ready=1; on frame_valid&&frame_ready, row=0, plane=0, go to SHIFT; frame_ready=0 in all other states.
REQ-021 SHIFT: lasts 1 cycle; shift_start=1 with shift_row=row, shift_plane=plane; then WAIT_SHIFT.
REQ-022 WAIT_SHIFT: hold until shift_done=1, then BLANK; shift_done outside WAIT_SHIFT is ignored.
REQ-023 BLANK: hub75_OE=1 for exactly DEADTIME cycles; hub75_addr takes row on the first BLANK cycle; then LATCH.
REQ-024 LATCH: hub75_latch=1 for exactly 1 cycle, OE still 1; then DISPLAY.
REQ-025 DISPLAY: hub75_OE=0 for exactly BASE_TICKS<<plane cycles; then NEXT.
REQ-026 NEXT: 1 cycle, OE=1; plane+1. On plane wrap (BIT_PLANES-1 to 0), row+1. On row wrap (SCAN_RATE-1 to 0), frame_done=1 this cycle and go to IDLE; otherwise go to SHIFT.
REQ-027 The DISPLAY counter SHALL be wide enough for BASE_TICKS<<(BIT_PLANES-1) without overflow.
REQ-028 hub75_OE SHALL be 0 only in DISPLAY; hub75_latch SHALL never be 1 while OE=0.
REQ-029 hub75_addr, hub75_latch, hub75_OE and shift_start SHALL be registered outputs.
REQ-030 frame_valid while not in IDLE SHALL be ignored and never queued.

Reset
REQ-031 While rst_in=0, asynchronously: state=IDLE, row=0, plane=0, hub75_OE=1, hub75_latch=0, hub75_addr=0, shift_start=0, frame_done=0, shift_err=0. frame_ready becomes 1 from the first cycle after release.
REQ-032 Reset asserted mid-frame SHALL abort immediately with no further shift_start or latch.

Configuration
REQ-033 Macro SCAN_WATCHDOG_EN, when defined: WAIT_SHIFT lasting WATCHDOG_CYCLES without shift_done forces OE=1, sets shift_err (sticky until reset) and returns to IDLE without frame_done.
REQ-034 Without SCAN_WATCHDOG_EN: WAIT_SHIFT waits indefinitely; shift_err is tied to 0.

Verification
REQ-035 Defaults, shift_done one cycle after every shift_start -> 96 shift_start pulses, 96 latches, per-row OE-low runs of 8/16/32 cycles (1792 OE-low cycles per frame), one frame_done, return to IDLE.
REQ-036 frame_valid held high after frame_done -> next frame accepted the cycle after IDLE entry; row restarts at 0.
REQ-037 shift_done pulsed during SHIFT and BLANK -> ignored; FSM advances only on shift_done in WAIT_SHIFT.
REQ-038 rst_in=0 during DISPLAY of row 17, plane 2 -> OE=1 and addr=0 asynchronously; after release, no activity until frame_valid.
REQ-039 SCAN_WATCHDOG_EN with shift_done withheld -> after 4096 WAIT_SHIFT cycles, shift_err=1, IDLE, no frame_done. Without the macro -> stays in WAIT_SHIFT, shift_err=0.
REQ-040 Every cycle, assertion checks (hub75_latch && !hub75_OE) never true, and that hub75_addr changes only while OE=1.
